// File: rtl/id_fwd_stage_pkg.sv
// Shared widths and forwarding-stage indices for the decode/forwarding stage.
// Imported by id_fwd_stage and id_fwd_mux.
package id_fwd_stage_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_AW        = 5;
  localparam int DEF_NSRC      = 2;
  localparam int DEF_NFWD      = 3;
  localparam int DEF_PAYLOAD_W = 64;

  // Producer stage indices: youngest first, so lower index wins a match.
  localparam int FWD_ES = 0;
  localparam int FWD_MS = 1;
  localparam int FWD_WS = 2;

  localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/id_fwd_stage_mux.sv
// Per-source operand resolver: picks the youngest matching producer,
// falls back to the register file, and flags a block when that producer is not ready.
module id_fwd_mux
  import id_fwd_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = DEF_AW,
  parameter int NFWD   = DEF_NFWD
) (
  input  logic                   src_use,
  input  logic [AW-1:0]          src_addr,
  input  logic [DATA_W-1:0]      rf_rdata,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD*AW-1:0]     fwd_dest,
  input  logic [NFWD*DATA_W-1:0] fwd_data,
  input  logic [NFWD-1:0]        fwd_data_ok,
  output logic [DATA_W-1:0]      value,
  output logic                   block
);

  logic found;

  always_comb begin
    value = rf_rdata;
    block = 1'b0;
    found = 1'b0;
    if (src_use) begin
      if (src_addr == '0) begin
        value = '0;
      end else begin
        // First hit from the young end decides both value and block.
        for (int k = 0; k < NFWD; k++) begin
          if (!found && fwd_valid[k] && (fwd_dest[k*AW +: AW] == src_addr)) begin
            found = 1'b1;
            value = fwd_data[k*DATA_W +: DATA_W];
            block = !fwd_data_ok[k];
          end
        end
      end
    end
  end

endmodule

// File: rtl/id_fwd_stage.sv
// Decode stage with operand forwarding and load-use interlock.
// Optional stall_cnt output enabled by defining ID_FWD_STALL_CNT_EN.
module id_fwd_stage
  import id_fwd_stage_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int AW        = DEF_AW,
  parameter int NSRC      = DEF_NSRC,
  parameter int NFWD      = DEF_NFWD,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   fs_to_ds_valid,
  input  logic [PAYLOAD_W-1:0]   fs_to_ds_bus,
  input  logic [NSRC*AW-1:0]     fs_src_addr,
  input  logic [NSRC-1:0]        fs_src_use,
  output logic                   ds_allowin,
  input  logic                   es_allowin,
  output logic                   ds_to_es_valid,
  output logic [PAYLOAD_W-1:0]   ds_to_es_bus,
  output logic [NSRC*DATA_W-1:0] ds_src_value,
  output logic [NSRC*AW-1:0]     rf_raddr,
  input  logic [NSRC*DATA_W-1:0] rf_rdata,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD*AW-1:0]     fwd_dest,
  input  logic [NFWD*DATA_W-1:0] fwd_data,
`ifdef ID_FWD_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
  input  logic [NFWD-1:0]        fwd_data_ok
);

  logic                 ds_valid;
  logic [PAYLOAD_W-1:0] ds_bus;
  logic [NSRC*AW-1:0]   ds_src_addr;
  logic [NSRC-1:0]      ds_src_use;
  logic [NSRC-1:0]      src_block;
  logic                 ds_ready_go;
  logic                 ds_capture;

  assign ds_ready_go    = ~|src_block;
  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go;
  // A flushed cycle captures nothing, so a dropped instruction leaves no residue.
  assign ds_capture     = fs_to_ds_valid && ds_allowin && !flush;

  assign ds_to_es_bus = ds_bus;
  assign rf_raddr     = ds_src_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid    <= 1'b0;
      ds_bus      <= '0;
      ds_src_addr <= '0;
      ds_src_use  <= '0;
    end else begin
      if (flush) begin
        ds_valid <= 1'b0;
      end else if (ds_allowin) begin
        ds_valid <= fs_to_ds_valid;
      end
      if (ds_capture) begin
        ds_bus      <= fs_to_ds_bus;
        ds_src_addr <= fs_src_addr;
        ds_src_use  <= fs_src_use;
      end
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    id_fwd_mux #(
      .DATA_W (DATA_W),
      .AW     (AW),
      .NFWD   (NFWD)
    ) u_mux (
      .src_use     (ds_src_use[i]),
      .src_addr    (ds_src_addr[i*AW +: AW]),
      .rf_rdata    (rf_rdata[i*DATA_W +: DATA_W]),
      .fwd_valid   (fwd_valid),
      .fwd_dest    (fwd_dest),
      .fwd_data    (fwd_data),
      .fwd_data_ok (fwd_data_ok),
      .value       (ds_src_value[i*DATA_W +: DATA_W]),
      .block       (src_block[i])
    );
  end

`ifdef ID_FWD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (ds_valid && !ds_ready_go && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_fwd_stage.sv
// Scoreboard bench for id_fwd_stage: directed hazard cases, then random traffic
// against a behavioural model. Checks stall_cnt when ID_FWD_STALL_CNT_EN is defined.
module tb_id_fwd_stage;
  import id_fwd_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int NF = 3;
  localparam int PW = 64;

  logic              clk = 1'b0;
  logic              reset, flush, fs_to_ds_valid, es_allowin;
  logic [PW-1:0]     fs_to_ds_bus;
  logic [NS*AW-1:0]  fs_src_addr;
  logic [NS-1:0]     fs_src_use;
  logic              ds_allowin, ds_to_es_valid;
  logic [PW-1:0]     ds_to_es_bus;
  logic [NS*DW-1:0]  ds_src_value;
  logic [NS*AW-1:0]  rf_raddr;
  logic [NS*DW-1:0]  rf_rdata;
  logic [NF-1:0]     fwd_valid, fwd_data_ok;
  logic [NF*AW-1:0]  fwd_dest;
  logic [NF*DW-1:0]  fwd_data;
`ifdef ID_FWD_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  logic [DW-1:0] rf_mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [PW-1:0]    bus;
    logic [NS*DW-1:0] vals;
  } xfer_t;
  xfer_t sb[$];

  // behavioural model state
  bit               m_v = 1'b0;
  logic [PW-1:0]    m_bus = '0;
  logic [AW-1:0]    m_addr [NS];
  bit               m_use [NS];
  longint unsigned  m_stall = 0;

  always #5 clk = ~clk;

  id_fwd_stage dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .fs_src_addr    (fs_src_addr),
    .fs_src_use     (fs_src_use),
    .ds_allowin     (ds_allowin),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .ds_src_value   (ds_src_value),
    .rf_raddr       (rf_raddr),
    .rf_rdata       (rf_rdata),
    .fwd_valid      (fwd_valid),
    .fwd_dest       (fwd_dest),
    .fwd_data       (fwd_data),
`ifdef ID_FWD_STALL_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .fwd_data_ok    (fwd_data_ok)
  );

  // register file: r0 reads as zero
  always_comb begin
    rf_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      if (rf_raddr[i*AW +: AW] != '0) rf_rdata[i*DW +: DW] = rf_mem[rf_raddr[i*AW +: AW]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: resolve operands from the rules, check handshakes, predict transfers.
  always @(negedge clk) begin
    logic [NS*DW-1:0] vals;
    bit rg, allow, blk;
    logic [DW-1:0] v;
    rg = 1'b1;
    vals = '0;
    for (int i = 0; i < NS; i++) begin
      v = (m_addr[i] == '0) ? '0 : rf_mem[m_addr[i]];
      blk = 1'b0;
      if (m_use[i] && m_addr[i] != '0) begin
        // scan oldest to youngest; the youngest hit overwrites the rest
        for (int k = NF - 1; k >= 0; k--) begin
          if (fwd_valid[k] && fwd_dest[k*AW +: AW] == m_addr[i]) begin
            v = fwd_data[k*DW +: DW];
            blk = !fwd_data_ok[k];
          end
        end
      end
      if (blk) rg = 1'b0;
      vals[i*DW +: DW] = v;
    end
    allow = !m_v || (rg && es_allowin);
    check("ds_allowin", 64'(ds_allowin), 64'(allow));
    check("ds_to_es_valid", 64'(ds_to_es_valid), 64'(m_v && rg));
`ifdef ID_FWD_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), m_stall);
`endif
    if (m_v && rg && es_allowin) sb.push_back('{bus: m_bus, vals: vals});
    if (reset) begin
      m_v = 1'b0; m_bus = '0; m_stall = 0;
      for (int i = 0; i < NS; i++) begin m_addr[i] = '0; m_use[i] = 1'b0; end
    end else begin
      if (m_v && !rg && m_stall != 64'hFFFF_FFFF) m_stall++;
      if (flush) m_v = 1'b0;
      else if (allow) begin
        m_v = fs_to_ds_valid;
        if (fs_to_ds_valid) begin
          m_bus = fs_to_ds_bus;
          for (int i = 0; i < NS; i++) begin
            m_addr[i] = fs_src_addr[i*AW +: AW];
            m_use[i]  = fs_src_use[i];
          end
        end
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT hands an instruction downstream.
  always @(negedge clk) begin
    xfer_t e;
    #2;
    if (ds_to_es_valid && es_allowin) begin
      if (sb.size() == 0) begin
        check("unexpected_xfer", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("xfer_bus", ds_to_es_bus, e.bus);
        check("xfer_vals", ds_src_value, e.vals);
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  task automatic set_idle();
    flush = 1'b0; fs_to_ds_valid = 1'b0; es_allowin = 1'b1;
    fwd_valid = '0; fwd_data_ok = '1; fwd_dest = '0; fwd_data = '0;
  endtask

  task automatic set_fwd(input int k, input bit vld, input logic [AW-1:0] d,
                         input logic [DW-1:0] data, input bit ok);
    fwd_valid[k] = vld;
    fwd_dest[k*AW +: AW] = d;
    fwd_data[k*DW +: DW] = data;
    fwd_data_ok[k] = ok;
  endtask

  task automatic issue(input logic [PW-1:0] p, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [NS-1:0] u);
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = p;
    fs_src_addr = {a1, a0}; fs_src_use = u;
  endtask

  initial begin
    longint unsigned st0;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    reset = 1'b1; fs_to_ds_bus = '0; fs_src_addr = '0; fs_src_use = '0;
    set_idle();
    repeat (3) step();
    reset = 1'b0;
    mid();
    check("rst_allowin", 64'(ds_allowin), 64'(1));
    check("rst_to_es_valid", 64'(ds_to_es_valid), 64'(0));
`ifdef ID_FWD_STALL_CNT_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif

    // youngest producer wins
    step(); issue(64'hA1A1_0000_0000_0041, 5'd5, 5'd9, 2'b11);
    step(); fs_to_ds_valid = 1'b0;
    set_fwd(FWD_ES, 1, 5'd5, 32'h11, 1);
    set_fwd(FWD_MS, 1, 5'd5, 32'h22, 1);
    mid();
    check("prio_valid", 64'(ds_to_es_valid), 64'(1));
    check("prio_src0", 64'(ds_src_value[31:0]), 64'h11);
    check("prio_src1", 64'(ds_src_value[63:32]), 64'(rf_mem[9]));
    check("prio_bus", ds_to_es_bus, 64'hA1A1_0000_0000_0041);
    step(); set_idle();

    // load-use stall for two cycles
    issue(64'hB2B2_0000_0000_0042, 5'd3, 5'd7, 2'b10);
    step(); fs_to_ds_valid = 1'b0;
    set_fwd(FWD_ES, 1, 5'd7, 32'h0, 0);
    for (int c = 0; c < 2; c++) begin
      mid(); check("stall_valid", 64'(ds_to_es_valid), 64'(0));
      step();
    end
    set_fwd(FWD_ES, 1, 5'd7, 32'h77, 1);
    mid();
    check("stall_release", 64'(ds_to_es_valid), 64'(1));
    check("stall_src1", 64'(ds_src_value[63:32]), 64'h77);
    check("stall_src0_unused", 64'(ds_src_value[31:0]), 64'(rf_mem[3]));
`ifdef ID_FWD_STALL_CNT_EN
    check("stall_cnt_two", 64'(stall_cnt), 64'(2));
`endif
    step(); set_idle();

    // r0 is never forwarded
    issue(64'hC3C3_0000_0000_0043, 5'd0, 5'd0, 2'b01);
    step(); fs_to_ds_valid = 1'b0;
    set_fwd(FWD_ES, 1, 5'd0, 32'hFF, 1);
    mid();
    check("r0_valid", 64'(ds_to_es_valid), 64'(1));
    check("r0_value", 64'(ds_src_value[31:0]), 64'(0));
    step(); set_idle();

    // flush during a stall
    issue(64'hD4D4_0000_0000_0044, 5'd3, 5'd0, 2'b01);
    step(); fs_to_ds_valid = 1'b0;
    set_fwd(FWD_ES, 1, 5'd3, 32'h0, 0);
    mid(); check("flush_pre_stall", 64'(ds_to_es_valid), 64'(0));
    step(); flush = 1'b1; issue(64'hDEAD_0000_0000_0045, 5'd3, 5'd0, 2'b01);
    step(); flush = 1'b0; fs_to_ds_valid = 1'b0;
    mid();
    check("flush_allowin", 64'(ds_allowin), 64'(1));
    check("flush_to_es_valid", 64'(ds_to_es_valid), 64'(0));
    step(); set_idle();

    // downstream back-pressure
    issue(64'hE5E5_0000_0000_0046, 5'd4, 5'd0, 2'b01);
    step(); issue(64'hF6F6_0000_0000_0047, 5'd6, 5'd0, 2'b01); es_allowin = 1'b0;
    st0 = m_stall;
    for (int c = 0; c < 3; c++) begin
      mid();
      check("bp_allowin", 64'(ds_allowin), 64'(0));
      check("bp_valid", 64'(ds_to_es_valid), 64'(1));
      check("bp_bus", ds_to_es_bus, 64'hE5E5_0000_0000_0046);
`ifdef ID_FWD_STALL_CNT_EN
      check("bp_stall_cnt", 64'(stall_cnt), st0);
`endif
      step();
    end
    es_allowin = 1'b1;
    step(); fs_to_ds_valid = 1'b0;
    mid(); check("bp_next_bus", ds_to_es_bus, 64'hF6F6_0000_0000_0047);
    step(); set_idle();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 29) == 0);
      fs_to_ds_valid = ($urandom_range(0, 9) < 7);
      fs_to_ds_bus = {$urandom, $urandom};
      for (int i = 0; i < NS; i++) fs_src_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      fs_src_use = NS'($urandom);
      es_allowin = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NF; k++)
        set_fwd(k, 1'($urandom), AW'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 4) != 0));
      step();
    end
    reset = 1'b0;
    set_idle();
    repeat (6) step();
    mid();
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
